// File: rtl/sa_arbiter.sv
// Round-robin arbiter sharing one systolic array between N_REQ matmul requesters.
// One operation at a time: grant, start pulse, wait for SA valid (watchdog-bounded), done/err pulse.
module sa_arb_lane (
  input  logic i_gnt,
  input  logic i_done_cyc,
  input  logic i_pe,
  output logic o_done,
  output logic o_pe
);
  assign o_done = i_gnt & i_done_cyc;
  assign o_pe   = i_gnt & i_pe;
endmodule

module sa_arbiter #(
  parameter int D_W     = 8,
  parameter int SA_R    = 16,
  parameter int SA_C    = 16,
  parameter int K_DIM   = 128,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                                           I_CLK,
  input  logic                                           I_SYNC_RSTN,
  input  logic [N_REQ-1:0]                               I_REQ,
  input  logic [N_REQ-1:0][SA_R-1:0][K_DIM-1:0][D_W-1:0] I_REQ_MAT_1,
  input  logic [N_REQ-1:0][K_DIM-1:0][SA_C-1:0][D_W-1:0] I_REQ_MAT_2,
  output logic [N_REQ-1:0]                               O_GNT,
  output logic [N_REQ-1:0]                               O_DONE,
  output logic [N_REQ-1:0]                               O_ERR,
  output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]             O_RESULT,
  output logic [N_REQ-1:0]                               O_PE_SHIFT,
  output logic                                           O_SA_START,
  output logic [SA_R-1:0][K_DIM-1:0][D_W-1:0]            O_MAT_1,
  output logic [K_DIM-1:0][SA_C-1:0][D_W-1:0]            O_MAT_2,
  input  logic                                           I_SA_VLD,
  input  logic                                           I_PE_SHIFT,
  input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]             I_SA_RESULT
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

  state_t                             r_state, w_state_nxt;
  logic [N_REQ-1:0]                   r_gnt, w_gnt_nxt;
  logic [IW-1:0]                      r_gnt_idx, w_gnt_idx_nxt;
  logic [IW-1:0]                      r_rr_ptr, w_rr_nxt;
  logic [WW-1:0]                      r_wd, w_wd_nxt;
  logic [N_REQ-1:0]                   r_err, w_err_nxt;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] r_result;
  logic                               w_cap;
  logic                               w_found;
  logic [IW-1:0]                      w_pick;
  logic [IW-1:0]                      w_ptr_inc;
  int                                 w_c;

  // First requester at or after rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_c     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_c = int'(r_rr_ptr) + k;
      if (w_c >= N_REQ) w_c = w_c - N_REQ;
      if (!w_found && I_REQ[IW'(w_c)]) begin
        w_found = 1'b1;
        w_pick  = IW'(w_c);
      end
    end
  end

  assign w_ptr_inc = (r_gnt_idx == IW'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_idx_nxt = r_gnt_idx;
    w_rr_nxt      = r_rr_ptr;
    w_wd_nxt      = r_wd;
    w_err_nxt     = '0;
    w_cap         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt     = N_REQ'(1) << w_pick;
          w_gnt_idx_nxt = w_pick;
          w_state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_wd_nxt    = '0;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_wd_nxt = r_wd + 1'b1;
        // A valid arriving on the last watchdog cycle still completes normally
        if (I_SA_VLD) begin
          w_cap       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_wd == WW'(TIMEOUT - 1)) begin
          w_err_nxt   = r_gnt;
          w_rr_nxt    = w_ptr_inc;
          w_gnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_rr_nxt    = w_ptr_inc;
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RSTN) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
      r_wd      <= '0;
      r_err     <= '0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_wd      <= w_wd_nxt;
      r_err     <= w_err_nxt;
      if (w_cap) r_result <= I_SA_RESULT;
    end
  end

  sa_arb_lane u_lane [N_REQ-1:0] (
    .i_gnt      (r_gnt),
    .i_done_cyc (r_state == S_DONE),
    .i_pe       (I_PE_SHIFT),
    .o_done     (O_DONE),
    .o_pe       (O_PE_SHIFT)
  );

  assign O_GNT      = r_gnt;
  assign O_ERR      = r_err;
  assign O_RESULT   = r_result;
  assign O_SA_START = (r_state == S_ISSUE);
  assign O_MAT_1    = (|r_gnt) ? I_REQ_MAT_1[r_gnt_idx] : '0;
  assign O_MAT_2    = (|r_gnt) ? I_REQ_MAT_2[r_gnt_idx] : '0;
endmodule

// File: tb/tb_sa_arbiter.sv
// Randomized bench for sa_arbiter: SA stub driver, round-robin reference model, scoreboard monitor.
module tb_sa_arbiter;
  localparam int D_W = 8, SA_R = 2, SA_C = 2, K_DIM = 4, N_REQ = 4, TIMEOUT = 40;
  localparam int IW = $clog2(N_REQ);
  localparam int RW = SA_R * SA_C * D_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]                               I_REQ = '0;
  logic [N_REQ-1:0][SA_R-1:0][K_DIM-1:0][D_W-1:0] mat1 = '0;
  logic [N_REQ-1:0][K_DIM-1:0][SA_C-1:0][D_W-1:0] mat2 = '0;
  logic [N_REQ-1:0]                               O_GNT, O_DONE, O_ERR, O_PE_SHIFT;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]             O_RESULT;
  logic                                           O_SA_START;
  logic [SA_R-1:0][K_DIM-1:0][D_W-1:0]            O_MAT_1;
  logic [K_DIM-1:0][SA_C-1:0][D_W-1:0]            O_MAT_2;
  logic                                           I_SA_VLD = 1'b0;
  logic                                           I_PE_SHIFT = 1'b0;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]             I_SA_RESULT = '0;

  sa_arbiter #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_DIM(K_DIM), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .I_CLK(clk), .I_SYNC_RSTN(rstn), .I_REQ(I_REQ), .I_REQ_MAT_1(mat1), .I_REQ_MAT_2(mat2),
    .O_GNT(O_GNT), .O_DONE(O_DONE), .O_ERR(O_ERR), .O_RESULT(O_RESULT), .O_PE_SHIFT(O_PE_SHIFT),
    .O_SA_START(O_SA_START), .O_MAT_1(O_MAT_1), .O_MAT_2(O_MAT_2), .I_SA_VLD(I_SA_VLD),
    .I_PE_SHIFT(I_PE_SHIFT), .I_SA_RESULT(I_SA_RESULT));

  typedef struct {
    bit              is_err;
    int              idx;
    logic [RW-1:0]   res;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0, bad = 0;
  int            ptr_m = 0;
  logic [RW-1:0] res_m = '0;
  int            n_ops = 0, n_starts = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; I_REQ = '0; I_SA_VLD = 1'b0;
    tick();
    check("rst_gnt", O_GNT, 0);
    check("rst_done", O_DONE, 0);
    check("rst_err", O_ERR, 0);
    check("rst_result", O_RESULT, 0);
    check("rst_start", O_SA_START, 0);
    check("rst_mat1", O_MAT_1, 0);
    check("rst_pe", O_PE_SHIFT, 0);
    rstn = 1'b1;
    ptr_m = 0; res_m = '0;
  endtask

  task automatic new_operands();
    for (int i = 0; i < N_REQ; i++)
      for (int r = 0; r < SA_R; r++)
        for (int k = 0; k < K_DIM; k++) mat1[i][r][k] = D_W'($urandom);
    for (int i = 0; i < N_REQ; i++)
      for (int k = 0; k < K_DIM; k++)
        for (int c = 0; c < SA_C; c++) mat2[i][k][c] = D_W'($urandom);
  endtask

  // Ticks until O_SA_START; exp_n is the spec latency from the current cycle
  task automatic wait_start(input int exp_n);
    int n;
    n = 0;
    do begin tick(); n++; end while (!O_SA_START && n < 20);
    check("start_latency", n, exp_n);
    n_ops++;
  endtask

  task automatic run_op(input int idx, input bit tmo, input int lat, output int next_n);
    logic [N_REQ-1:0] g;
    logic             pe;
    logic [RW-1:0]    data;
    g = '0; g[IW'(idx)] = 1'b1;
    check("gnt", O_GNT, g);
    check("mat1_issue", O_MAT_1, mat1[idx]);
    check("mat2_issue", O_MAT_2, mat2[idx]);
    pe = 1'($urandom); I_PE_SHIFT = pe;
    #1 check("pe_shift", O_PE_SHIFT, {N_REQ{pe}} & g);
    if (!tmo) begin
      for (int c = 1; c <= lat; c++) begin
        tick();
        if (c < lat) I_SA_RESULT = RW'($urandom);
      end
      data = RW'($urandom);
      I_SA_RESULT = data; I_SA_VLD = 1'b1;
      sbq.push_back('{is_err: 1'b0, idx: idx, res: data});
      res_m = data;
      tick();
      I_SA_VLD = 1'b0; I_SA_RESULT = RW'($urandom); I_REQ[IW'(idx)] = 1'b0;
      check("gnt_done", O_GNT, g);
      check("mat1_done", O_MAT_1, mat1[idx]);
      next_n = 2;
    end else begin
      for (int c = 1; c <= TIMEOUT; c++) begin
        tick();
        I_SA_RESULT = RW'($urandom);
      end
      sbq.push_back('{is_err: 1'b1, idx: idx, res: res_m});
      tick();
      I_REQ[IW'(idx)] = 1'b0;
      check("err_timing", O_ERR, g);
      check("gnt_after_err", O_GNT, 0);
      check("mat1_idle", O_MAT_1, 0);
      next_n = 1;
    end
  endtask

  // Serve a set of simultaneous requests; fixed_lat=0 means random latency with occasional timeouts
  task automatic run_phase(input logic [N_REQ-1:0] mask, input int fixed_lat);
    logic [N_REQ-1:0] pend;
    int nn, idx, lat;
    bit tmo;
    new_operands();
    pend = mask; nn = 1;
    I_REQ = mask;
    while (pend != 0) begin
      idx = ptr_m;
      while (!pend[IW'(idx)]) idx = (idx + 1) % N_REQ;
      wait_start(nn);
      tmo = (fixed_lat == 0) && ($urandom_range(0, 5) == 0);
      lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8));
      run_op(idx, tmo, lat, nn);
      pend[IW'(idx)] = 1'b0;
      ptr_m = (idx + 1) % N_REQ;
    end
    repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        logic [N_REQ-1:0] ev;
        @(negedge clk);
        if (O_SA_START) n_starts++;
        if (O_DONE != 0 || O_ERR != 0) begin
          if (sbq.size() == 0) begin
            check("unexpected_done_err", {O_DONE, O_ERR}, 0);
          end else begin
            e = sbq.pop_front();
            ev = '0; ev[IW'(e.idx)] = 1'b1;
            check("done_vec", O_DONE, e.is_err ? '0 : ev);
            check("err_vec", O_ERR, e.is_err ? ev : '0);
            check("result", O_RESULT, e.res);
          end
        end
      end
    join_none

    do_reset();
    run_phase(4'b0100, 20);
    run_phase(4'b1111, 3);
    do_reset();
    run_phase(4'b1111, 2);
    run_phase(4'b1111, 0);
    run_phase(4'b0010, TIMEOUT);
    repeat (20) begin
      logic [N_REQ-1:0] m;
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_phase(m, 0);
    end

    // Reset in the middle of BUSY abandons the operation
    I_REQ = 4'b1000;
    wait_start(1);
    repeat (3) tick();
    do_reset();
    I_SA_VLD = 1'b1; I_SA_RESULT = RW'($urandom);
    tick();
    I_SA_VLD = 1'b0;
    repeat (5) tick();
    check("result_after_rst", O_RESULT, 0);
    check("gnt_after_rst", O_GNT, 0);
    run_phase(4'b1001, 0);

    repeat (3) tick();
    check("scoreboard_empty", sbq.size(), 0);
    check("start_count", n_starts, n_ops);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
